ex_muldiv_stage: RTL

EX_MULDIV_STAGE -- requirements
Module: ex_muldiv_stage

---
 rtl/ex_muldiv_stage.sv | 119 +++++++++++
 1 files changed

// File: rtl/ex_muldiv_stage.sv
// ex_muldiv_stage: execute stage with operand forwarding, operand muxes and a radix-2 multiply/divide unit owning HI/LO
module ex_muldiv_stage #(
  parameter int WIDTH = 32,
  parameter int AW = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegDst_ex,
  input  logic             ALUSrcA_ex,
  input  logic             ALUSrcB_ex,
  input  logic [WIDTH-1:0] Imm_ex,
  input  logic [WIDTH-1:0] Sa_ex,
  input  logic [WIDTH-1:0] RsData_ex,
  input  logic [WIDTH-1:0] RtData_ex,
  input  logic [AW-1:0]    RsAddr_ex,
  input  logic [AW-1:0]    RtAddr_ex,
  input  logic [AW-1:0]    RdAddr_ex,
  input  logic [WIDTH-1:0] ALUResult_mem,
  input  logic [WIDTH-1:0] RegWriteData_wb,
  input  logic [AW-1:0]    RegWriteAddr_mem,
  input  logic [AW-1:0]    RegWriteAddr_wb,
  input  logic             RegWrite_mem,
  input  logic             RegWrite_wb,
  input  logic [2:0]       MdOp_ex,
  input  logic [1:0]       MfSel_ex,
  input  logic [WIDTH-1:0] AluResult_in,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic [WIDTH-1:0] MemWriteData_ex,
  output logic [WIDTH-1:0] ExResult_ex,
  output logic [AW-1:0]    RegWriteAddr_ex,
  output logic             Stall_ex,
  output logic             DivByZero
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] hi, lo, acc_hi, acc_lo, op_b;
  logic is_div, neg_q, neg_r;
  logic [WIDTH-1:0] fwd_rs, fwd_rt, abs_a, abs_b;
  logic md_start, op_signed, op_div, div_zero;
  logic [WIDTH:0] mul_sum, div_trial;
  logic [WIDTH-1:0] step_hi, step_lo, fin_q, fin_r, final_hi, final_lo;
  logic [2*WIDTH-1:0] fin_prod;
  assign fwd_rs = (RegWrite_mem && RegWriteAddr_mem != '0 && RegWriteAddr_mem == RsAddr_ex) ? ALUResult_mem :
                  (RegWrite_wb && RegWriteAddr_wb != '0 && RegWriteAddr_wb == RsAddr_ex) ? RegWriteData_wb : RsData_ex;
  assign fwd_rt = (RegWrite_mem && RegWriteAddr_mem != '0 && RegWriteAddr_mem == RtAddr_ex) ? ALUResult_mem :
                  (RegWrite_wb && RegWriteAddr_wb != '0 && RegWriteAddr_wb == RtAddr_ex) ? RegWriteData_wb : RtData_ex;
  assign ALU_A = ALUSrcA_ex ? Sa_ex : fwd_rs;
  assign ALU_B = ALUSrcB_ex ? Imm_ex : fwd_rt;
  assign MemWriteData_ex = fwd_rt;
  assign RegWriteAddr_ex = RegDst_ex ? RdAddr_ex : RtAddr_ex;
  assign ExResult_ex = (MfSel_ex == 2'd1) ? hi : (MfSel_ex == 2'd2) ? lo : AluResult_in;
  assign md_start = MdOp_ex >= 3'd1 && MdOp_ex <= 3'd4;
  assign op_signed = MdOp_ex == 3'd1 || MdOp_ex == 3'd3;
  assign op_div = MdOp_ex == 3'd3 || MdOp_ex == 3'd4;
  assign div_zero = op_div && fwd_rt == '0;
  assign abs_a = (op_signed && fwd_rs[WIDTH-1]) ? -fwd_rs : fwd_rs;
  assign abs_b = (op_signed && fwd_rt[WIDTH-1]) ? -fwd_rt : fwd_rt;
  assign Stall_ex = (state == IDLE && md_start) || state == RUN;
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_b} : '0);
  assign div_trial = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, op_b};
  assign step_hi = is_div ? (div_trial[WIDTH] ? {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]} : div_trial[WIDTH-1:0]) : mul_sum[WIDTH:1];
  assign step_lo = is_div ? {acc_lo[WIDTH-2:0], ~div_trial[WIDTH]} : {mul_sum[0], acc_lo[WIDTH-1:1]};
  assign fin_prod = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
  assign fin_q = neg_q ? -step_lo : step_lo;
  assign fin_r = neg_r ? -step_hi : step_hi;
  assign final_hi = is_div ? fin_r : fin_prod[2*WIDTH-1:WIDTH];
  assign final_lo = is_div ? fin_q : fin_prod[WIDTH-1:0];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      DivByZero <= 1'b0;
      acc_hi <= '0;
      acc_lo <= '0;
      op_b <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      DivByZero <= 1'b0;
      case (state)
        IDLE: begin
          if (md_start && div_zero) begin
            DivByZero <= 1'b1;
            state <= DONE;
          end else if (md_start) begin
            acc_hi <= '0;
            acc_lo <= abs_a;
            op_b <= abs_b;
            is_div <= op_div;
            neg_q <= op_signed && (fwd_rs[WIDTH-1] ^ fwd_rt[WIDTH-1]);
            neg_r <= op_signed && fwd_rs[WIDTH-1];
            cnt <= CW'(WIDTH);
            state <= RUN;
          end else begin
            if (MdOp_ex == 3'd5) hi <= fwd_rs;
            if (MdOp_ex == 3'd6) lo <= fwd_rs;
          end
        end
        RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            hi <= final_hi;
            lo <= final_lo;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
